// File: rtl/mem_access_pkg.sv
// Shared constants, state encoding and access-size helpers for the memory-access stage.
package mem_access_pkg;

  localparam int REG       = 32;
  localparam int MEM_ADDR  = 32;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  // Unused funct3 codes (011, 110, 111) fall through to a full word access.
  function automatic mem_size_e f3_size(input logic [2:0] f3);
    case (f3)
      LB, LBU: f3_size = SZ_BYTE;
      LH, LHU: f3_size = SZ_HALF;
      default: f3_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic [1:0] aligned_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3_size(f3))
      SZ_BYTE: aligned_off = off;
      SZ_HALF: aligned_off = {off[1], 1'b0};
      default: aligned_off = 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    misaligned = (aligned_off(f3, off) != off);
  endfunction

endpackage

// File: rtl/mem_access_lsu_lane.sv
// Byte-lane steering for stores and load extraction with sign/zero extension (combinational).
module lsu_lane
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic        is_store_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_word_i[{off_i, 3'b000} +: 8];
  assign ld_half = ld_word_i[{off_i[1], 4'b0000} +: 16];

  // off_i arrives already forced to natural alignment for the access size.
  always_comb begin
    be_o      = 4'b1111;
    wdata_o   = st_data_i;
    ld_data_o = ld_word_i;
    case (f3_size(funct3_i))
      SZ_BYTE: begin
        if (is_store_i) be_o = 4'b0001 << off_i;
        wdata_o   = {4{st_data_i[7:0]}};
        ld_data_o = funct3_i[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        if (is_store_i) be_o = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{st_data_i[15:0]}};
        ld_data_o = funct3_i[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: single-outstanding req/ack data bus with timeout and stall.
// Optional misaligned-access trapping is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic        clk_100MHz,
  input  logic        arst_n,
  input  logic        mem_r_ena_i,
  input  logic [31:0] mem_r_addr_i,
  input  logic        mem_w_ena_i,
  input  logic [31:0] mem_w_addr_i,
  input  logic [31:0] mem_w_data_i,
  input  logic [31:0] inst_i,
  input  logic        reg_w_ena_i,
  input  logic [4:0]  reg_w_addr_i,
  input  logic [31:0] reg_w_data_i,
  output logic        reg_w_ena_o,
  output logic [4:0]  reg_w_addr_o,
  output logic [31:0] reg_w_data_o,
  output logic        hold_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        bus_err_o,
  output logic        misalign_o
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d, req_q, req_d, err_q, err_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        access, is_store, mis;
  logic [31:0] cur_addr;
  logic [2:0]  cur_f3;
  logic [1:0]  cur_off;
  logic        lane_idle;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_ld;
  logic        unused_inst;

  assign access      = mem_r_ena_i | mem_w_ena_i;
  assign is_store    = mem_w_ena_i;
  assign cur_addr    = is_store ? mem_w_addr_i : mem_r_addr_i;
  assign cur_f3      = inst_i[14:12];
  assign cur_off     = aligned_off(cur_f3, cur_addr[1:0]);
  assign unused_inst = ^{inst_i[31:15], inst_i[11:0]};

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = misaligned(cur_f3, cur_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  // The lane is shared: the current request drives it in IDLE, latched fields otherwise.
  assign lane_idle = (state_q == MEM_IDLE);

  lsu_lane u_lane (
    .funct3_i   (lane_idle ? cur_f3 : f3_q),
    .off_i      (lane_idle ? cur_off : off_q),
    .is_store_i (lane_idle ? is_store : we_q),
    .st_data_i  (mem_w_data_i),
    .ld_word_i  (rdata_q),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .ld_data_o  (lane_ld)
  );

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= MEM_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      req_q   <= req_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
    end
  end

  // Writeback is suppressed whenever the stage stalls so MEM/WB captures a bubble.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    be_d         = be_q;
    we_d         = we_q;
    req_d        = req_q;
    err_d        = err_q;
    f3_d         = f3_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    reg_w_ena_o  = reg_w_ena_i;
    reg_w_addr_o = reg_w_addr_i;
    reg_w_data_o = reg_w_data_i;
    hold_o       = 1'b0;
    bus_err_o    = 1'b0;
    misalign_o   = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (access && mis) begin
          misalign_o  = 1'b1;
          reg_w_ena_o = WRITE_DISABLE;
        end else if (access) begin
          hold_o      = 1'b1;
          reg_w_ena_o = WRITE_DISABLE;
          addr_d      = {cur_addr[31:2], 2'b00};
          be_d        = lane_be;
          wdata_d     = lane_wdata;
          we_d        = is_store;
          f3_d        = cur_f3;
          off_d       = cur_off;
          req_d       = 1'b1;
          err_d       = 1'b0;
          cnt_d       = '0;
          state_d     = MEM_BUSY;
        end
      end
      MEM_BUSY: begin
        hold_o      = 1'b1;
        reg_w_ena_o = WRITE_DISABLE;
        if (dbus_ack_i) begin
          rdata_d = dbus_rdata_i;
          req_d   = 1'b0;
          state_d = MEM_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = MEM_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      MEM_DONE: begin
        if (err_q) begin
          reg_w_ena_o = WRITE_DISABLE;
          bus_err_o   = 1'b1;
        end else if (we_q) begin
          reg_w_ena_o = WRITE_DISABLE;
        end else begin
          reg_w_data_o = lane_ld;
        end
        state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against a byte-level reference model.
module tb_mem_access;

  localparam int TO = 4;

  logic        clk_100MHz = 1'b0;
  logic        arst_n = 1'b0;
  logic        mem_r_ena_i, mem_w_ena_i, reg_w_ena_i, dbus_ack_i;
  logic [31:0] mem_r_addr_i, mem_w_addr_i, mem_w_data_i, inst_i, reg_w_data_i, dbus_rdata_i;
  logic [4:0]  reg_w_addr_i;
  logic        reg_w_ena_o, hold_o, dbus_req_o, dbus_we_o, bus_err_o, misalign_o;
  logic [4:0]  reg_w_addr_o;
  logic [31:0] reg_w_data_o, dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;

  int checks = 0;
  int fails  = 0;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_100MHz   (clk_100MHz),
    .arst_n       (arst_n),
    .mem_r_ena_i  (mem_r_ena_i),
    .mem_r_addr_i (mem_r_addr_i),
    .mem_w_ena_i  (mem_w_ena_i),
    .mem_w_addr_i (mem_w_addr_i),
    .mem_w_data_i (mem_w_data_i),
    .inst_i       (inst_i),
    .reg_w_ena_i  (reg_w_ena_i),
    .reg_w_addr_i (reg_w_addr_i),
    .reg_w_data_i (reg_w_data_i),
    .reg_w_ena_o  (reg_w_ena_o),
    .reg_w_addr_o (reg_w_addr_o),
    .reg_w_data_o (reg_w_data_o),
    .hold_o       (hold_o),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_be_o    (dbus_be_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_rdata_i (dbus_rdata_i),
    .dbus_ack_i   (dbus_ack_i),
    .bus_err_o    (bus_err_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes and natural-alignment byte offset.
  function automatic int sizeOf(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: sizeOf = 1;
      3'd1, 3'd5: sizeOf = 2;
      default:    sizeOf = 4;
    endcase
  endfunction

  function automatic int alignedOff(input logic [2:0] f3, input logic [31:0] a);
    int n = sizeOf(f3);
    alignedOff = (int'(a % 4) / n) * n;
  endfunction

  function automatic logic [31:0] loadModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int n = sizeOf(f3);
    logic [31:0] v = rd >> (8 * alignedOff(f3, a));
    if (n == 1)      loadModel = f3[2] ? (v & 32'hFF)   : 32'($signed(v[7:0]));
    else if (n == 2) loadModel = f3[2] ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
    else             loadModel = rd;
  endfunction

  function automatic logic [3:0] storeBe(input logic [2:0] f3, input logic [31:0] a);
    int n = sizeOf(f3);
    int o = alignedOff(f3, a);
    for (int i = 0; i < 4; i++) storeBe[i] = (i >= o) && (i < o + n);
  endfunction

  function automatic logic [31:0] storeData(input logic [2:0] f3, input logic [31:0] d);
    int n = sizeOf(f3);
    for (int i = 0; i < 4; i++) storeData[8*i +: 8] = d[8*(i % n) +: 8];
  endfunction

  task automatic idleInputs();
    mem_r_ena_i = 0; mem_w_ena_i = 0; mem_r_addr_i = 0; mem_w_addr_i = 0;
    mem_w_data_i = 0; inst_i = 0; reg_w_ena_i = 0; reg_w_addr_i = 0;
    reg_w_data_i = 0; dbus_ack_i = 0; dbus_rdata_i = 0;
  endtask

  // kind: 0 none, 1 load, 2 store, 3 load+store; waits < 0 means never ack.
  task automatic applyStimulus(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input int waits, input logic [31:0] rd);
    logic [31:0] rwd = $urandom;
    logic [4:0]  rwa = 5'($urandom);
    logic        rwe = 1'($urandom);
    logic [31:0] ins = $urandom;
    bit store  = (kind >= 2);
    bit access = (kind != 0);
    bit mis    = (addr % sizeOf(f3)) != 0;
    int nb     = (waits < 0) ? TO : waits + 1;
    @(posedge clk_100MHz); #1;
    ins[14:12]   = f3;
    mem_r_ena_i  = (kind == 1) || (kind == 3);
    mem_w_ena_i  = store;
    mem_r_addr_i = (kind == 3) ? $urandom : addr;
    mem_w_addr_i = store ? addr : $urandom;
    mem_w_data_i = wd;
    inst_i       = ins;
    reg_w_ena_i  = rwe;
    reg_w_addr_i = rwa;
    reg_w_data_i = rwd;
    dbus_ack_i   = 1'($urandom);
    dbus_rdata_i = $urandom;
    @(negedge clk_100MHz);
    checkOutput("addr_pass", 32'(reg_w_addr_o), 32'(rwa));
    if (!access) begin
      checkOutput("pass_hold", 32'(hold_o), 0);
      checkOutput("pass_ena", 32'(reg_w_ena_o), 32'(rwe));
      checkOutput("pass_data", reg_w_data_o, rwd);
      @(posedge clk_100MHz); #1;
      idleInputs();
    end else if (TRAP && mis) begin
      checkOutput("mis_pulse", 32'(misalign_o), 1);
      checkOutput("mis_hold", 32'(hold_o), 0);
      checkOutput("mis_ena", 32'(reg_w_ena_o), 0);
      @(posedge clk_100MHz); #1;
      idleInputs();
      @(negedge clk_100MHz);
      checkOutput("mis_noreq", 32'(dbus_req_o), 0);
      checkOutput("mis_end", 32'(misalign_o), 0);
    end else begin
      checkOutput("idle_hold", 32'(hold_o), 1);
      checkOutput("idle_ena", 32'(reg_w_ena_o), 0);
      @(posedge clk_100MHz); #1;
      dbus_ack_i = 0;
      for (int c = 0; c < nb; c++) begin
        @(negedge clk_100MHz);
        checkOutput("busy_req", 32'(dbus_req_o), 1);
        checkOutput("busy_hold", 32'(hold_o), 1);
        if (c == 0) begin
          checkOutput("bus_addr", dbus_addr_o, addr & 32'hFFFF_FFFC);
          checkOutput("bus_we", 32'(dbus_we_o), 32'(store));
          checkOutput("bus_be", 32'(dbus_be_o), store ? 32'(storeBe(f3, addr)) : 32'hF);
          if (store) checkOutput("bus_wdata", dbus_wdata_o, storeData(f3, wd));
        end
        if (c == nb - 1 && waits >= 0) begin
          dbus_ack_i = 1; dbus_rdata_i = rd;
        end else begin
          dbus_ack_i = 0; dbus_rdata_i = $urandom;
        end
        @(posedge clk_100MHz); #1;
        dbus_ack_i = 0;
        dbus_rdata_i = $urandom;
      end
      @(negedge clk_100MHz);
      checkOutput("done_hold", 32'(hold_o), 0);
      checkOutput("done_req", 32'(dbus_req_o), 0);
      checkOutput("done_err", 32'(bus_err_o), 32'(waits < 0));
      checkOutput("done_ena", 32'(reg_w_ena_o), (waits < 0 || store) ? 0 : 32'(rwe));
      if (waits >= 0 && !store) checkOutput("load_data", reg_w_data_o, loadModel(f3, addr, rd));
      @(posedge clk_100MHz); #1;
      idleInputs();
      @(negedge clk_100MHz);
      checkOutput("back_idle_hold", 32'(hold_o), 0);
      checkOutput("back_idle_err", 32'(bus_err_o), 0);
    end
  endtask

  initial begin
    idleInputs();
    repeat (3) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    checkOutput("rst_req", 32'(dbus_req_o), 0);
    checkOutput("rst_we", 32'(dbus_we_o), 0);
    checkOutput("rst_addr", dbus_addr_o, 0);
    checkOutput("rst_be", 32'(dbus_be_o), 0);
    checkOutput("rst_wdata", dbus_wdata_o, 0);
    checkOutput("rst_err", 32'(bus_err_o), 0);
    checkOutput("rst_mis", 32'(misalign_o), 0);
    checkOutput("rst_hold", 32'(hold_o), 0);
    arst_n = 1;

    applyStimulus(0, 3'd0, 32'h0, 32'h0, 0, 32'h0);
    applyStimulus(1, 3'd0, 32'h103, 32'h0, 0, 32'h80FF_FF00);
    applyStimulus(1, 3'd5, 32'h202, 32'h0, 1, 32'h8001_0000);
    applyStimulus(2, 3'd0, 32'h301, 32'hAB, 2, 32'h0);
    applyStimulus(2, 3'd1, 32'h502, 32'hCAFE_1234, 0, 32'h0);
    applyStimulus(1, 3'd2, 32'h600, 32'h0, -1, 32'h0);
    applyStimulus(1, 3'd4, 32'h701, 32'h0, TO - 1, 32'h0000_F000);
    applyStimulus(3, 3'd2, 32'h804, 32'h1122_3344, 0, 32'h0);
    applyStimulus(1, 3'd2, 32'h402, 32'h0, 0, 32'hDEAD_BEEF);

    // Reset in the middle of a pending load must drop the request at once.
    @(posedge clk_100MHz); #1;
    mem_r_ena_i = 1; mem_r_addr_i = 32'h900; inst_i = 32'h0000_2000;
    @(posedge clk_100MHz); #1;
    @(negedge clk_100MHz);
    checkOutput("pre_rst_req", 32'(dbus_req_o), 1);
    arst_n = 0;
    #1;
    checkOutput("async_rst_req", 32'(dbus_req_o), 0);
    idleInputs();
    @(negedge clk_100MHz);
    arst_n = 1;
    checkOutput("post_rst_hold", 32'(hold_o), 0);

    for (int t = 0; t < 60; t++) begin
      int w = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      applyStimulus(int'($urandom_range(0, 3)), 3'($urandom), $urandom, $urandom, w, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the 5-stage RISC-V pipeline, between the EX/MEM pipeline register and the MEM/WB register. It turns load/store requests into transactions on a single-outstanding data bus with req/ack handshake, byte-lane steering and load sign/zero extension. It stalls the pipeline through `hold_o` while a transaction is in flight. Non-memory instructions pass through with zero latency.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: BUSY cycles without `dbus_ack_i` before abort; range 1..255.

Ports (reset arst_n, asynchronous, active-low; clock clk_100MHz):
- `clk_100MHz` in 1: 100 MHz clock
- `arst_n` in 1: asynchronous active-low reset
- `mem_r_ena_i` in 1: load request from EX/MEM
- `mem_r_addr_i` in 32: load byte address
- `mem_w_ena_i` in 1: store request
- `mem_w_addr_i` in 32: store byte address
- `mem_w_data_i` in 32: store data, unaligned (bits [7:0]/[15:0]/[31:0] valid)
- `inst_i` in 32: instruction; funct3 = `inst_i[14:12]`
- `reg_w_ena_i` in 1, `reg_w_addr_i` in 5, `reg_w_data_i` in 32: writeback info from EX
- `reg_w_ena_o` out 1, `reg_w_addr_o` out 5, `reg_w_data_o` out 32: to MEM/WB
- `hold_o` out 1: stall request to PC, IF/ID, ID/EX, EX/MEM
- `dbus_req_o` out 1, `dbus_we_o` out 1, `dbus_addr_o` out 32 (word-aligned), `dbus_be_o` out 4, `dbus_wdata_o` out 32: data bus request
- `dbus_rdata_i` in 32, `dbus_ack_i` in 1: data bus response
- `bus_err_o` out 1: one-cycle pulse on timeout
- `misalign_o` out 1: one-cycle pulse on misaligned access (see Configuration)

## Operation
- Access = `mem_r_ena_i | mem_w_ena_i`. Both high: store wins, load ignored.
- Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store: 000 SB, 001 SH, 010 SW. Other funct3: treat as LW/SW.
- Store lanes: SB `be = 1<<a[1:0]`, data byte replicated ×4. SH `be = a[1] ? 1100 : 0011`, halfword replicated ×2. SW `be = 1111`. Loads: `be = 1111`, `we = 0`.
- Load extract: byte/halfword selected by `a[1:0]`, sign- or zero-extended to 32 bits.
- FSM states:
  - IDLE: no access → pass-through `reg_w_*_o = reg_w_*_i`, `hold_o = 0`. Access → `hold_o = 1` combinationally; next edge latch addr/be/wdata/we/funct3, `dbus_req_o <= 1`, go BUSY.
  - BUSY: `hold_o = 1`, request outputs stable. On `dbus_ack_i`: capture `dbus_rdata_i`, drop req, go DONE. Timeout counter reaches `TIMEOUT_CYCLES`: drop req, set error flag, go DONE.
  - DONE: `hold_o = 0`. Load: `reg_w_data_o` = extended captured data, `reg_w_ena_o = reg_w_ena_i`. Store: `reg_w_ena_o = 0`. Error: `reg_w_ena_o = 0`, `bus_err_o = 1`. Next edge: IDLE.
- `reg_w_addr_o` always equals `reg_w_addr_i`.
- `dbus_ack_i` outside BUSY is ignored.

## Timing
- Non-memory instruction: 0 extra cycles.
- Access with ack in the first BUSY cycle: 3 cycles in stage (IDLE, BUSY, DONE), `hold_o` high 2 cycles. Each extra wait cycle adds 1.
- Timeout: DONE is entered on the edge after BUSY cycle number `TIMEOUT_CYCLES` without ack.
- Reset values: state IDLE, `dbus_req_o` 0, `dbus_we_o` 0, `dbus_addr_o` 0, `dbus_be_o` 0, `dbus_wdata_o` 0, `bus_err_o` 0, `misalign_o` 0, `hold_o` 0. `reg_w_*_o` follow the EX/MEM reset zeros.
- Reset asserted mid-transaction: request dropped immediately (async), no writeback, FSM returns to IDLE.
- Ack and timeout in the same cycle: ack wins, no error.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Misaligned access (LH/LHU/SH with `a[0]`, LW/SW with `a[1:0] != 0`) is not issued.
  - `misalign_o` pulses for one cycle while in IDLE, `reg_w_ena_o = 0`, `hold_o = 0`.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - Low address bits are forced to natural alignment and the access is issued.
  - `misalign_o` is tied 0.

## Structure
- Shared constants in `define.v`:
  - funct3 codes (`LB`..`LHU`, `SB`..`SW`)
  - FSM encodings `MEM_IDLE`/`MEM_BUSY`/`MEM_DONE`
  - existing `REG`, `MEM_ADDR`, `WRITE_DISABLE`
- Sub-module `lsu_lane`: purely combinational. Computes store be/wdata and load extract/extend from funct3 and `a[1:0]`. FSM, timeout counter and latches stay in `mem_access`.

## Test plan
- ADD passes through: `reg_w_data_i = 0x1234` → `reg_w_data_o = 0x1234` same cycle, `hold_o` never high.
- LB at 0x103, rdata 0x80FF_FF00, ack in first BUSY cycle → `dbus_addr_o = 0x100`, `be = 1111`, `reg_w_data_o = 0xFFFF_FF80` in DONE, `hold_o` high 2 cycles.
- LHU at 0x202, rdata 0x8001_0000 → `reg_w_data_o = 0x0000_8001`.
- SB at 0x301, data 0xAB → `be = 0010`, `wdata = 0xABAB_ABAB`, `we = 1`, `reg_w_ena_o = 0`.
- No ack, `TIMEOUT_CYCLES = 4` → req drops after 4 BUSY cycles, `bus_err_o` pulses once, no writeback. Separately: `arst_n` low during BUSY → `dbus_req_o` 0 immediately.
- With `MEM_MISALIGN_TRAP_EN`, LW at 0x402 → no `dbus_req_o`, `misalign_o` one-cycle pulse. Without it → `dbus_addr_o = 0x400` issued.
